// File: rtl/conv_encoder.sv
// Rate-1/2, K=3 convolutional encoder (g0=7, g1=5 octal) feeding the Viterbi decoder.
// Bytes arrive on a valid/ready stream and are serialised MSB first. Optional zero tail bits return the trellis to S0.
module conv_encoder #(
    parameter bit TERMINATE = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    input  logic [7:0] s_data_i,
    input  logic       s_last_i,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output logic [1:0] m_sym_o,
    output logic       m_last_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        WAIT = 2'd2,
        TAIL = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] enc_q, enc_d;        // {s1 newest, s0 older}
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       tail_cnt_q, tail_cnt_d;

    logic u, c0, c1;
    logic fire, accept, final_bit;

    always_comb begin
        u  = (state_q == DATA) ? data_q[7] : 1'b0;
        c0 = u ^ enc_q[1] ^ enc_q[0];
        c1 = u ^ enc_q[0];
    end

    assign m_valid_o = (state_q == DATA) || (state_q == TAIL);
    assign fire      = m_valid_o && m_ready_i;
    assign final_bit = (state_q == DATA) && (bit_cnt_q == 3'd7);

    // Taking the next byte on the final-bit fire keeps the symbol stream gapless.
    assign s_ready_o = (state_q == IDLE) || (state_q == WAIT) ||
                       (final_bit && m_ready_i && !last_q);
    assign accept    = s_valid_i && s_ready_o;

    assign m_sym_o  = m_valid_o ? {c0, c1} : 2'b00;
    assign m_last_o = TERMINATE ? ((state_q == TAIL) && tail_cnt_q)
                                : (final_bit && last_q);

    always_comb begin
        state_d    = state_q;
        enc_d      = enc_q;
        data_d     = data_q;
        last_d     = last_q;
        bit_cnt_d  = bit_cnt_q;
        tail_cnt_d = tail_cnt_q;

        case (state_q)
            IDLE: begin
                enc_d = 2'b00;
                if (accept) state_d = DATA;
            end
            WAIT: begin
                if (accept) state_d = DATA;
            end
            DATA: begin
                if (fire) begin
                    enc_d     = {u, enc_q[1]};
                    data_d    = {data_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (last_q) begin
                            if (TERMINATE) begin
                                state_d    = TAIL;
                                tail_cnt_d = 1'b0;
                            end else begin
                                state_d = IDLE;
                                enc_d   = 2'b00;
                            end
                        end else if (accept) begin
                            state_d = DATA;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
            end
            TAIL: begin
                if (fire) begin
                    enc_d      = {1'b0, enc_q[1]};
                    tail_cnt_d = ~tail_cnt_q;
                    if (tail_cnt_q) begin
                        state_d    = IDLE;
                        tail_cnt_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A freshly accepted byte overrides the shift of the byte just finished.
        if (accept) begin
            data_d    = s_data_i;
            last_d    = s_last_i;
            bit_cnt_d = 3'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            enc_q      <= 2'b00;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            bit_cnt_q  <= 3'd0;
            tail_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            enc_q      <= enc_d;
            data_q     <= data_d;
            last_q     <= last_d;
            bit_cnt_q  <= bit_cnt_d;
            tail_cnt_q <= tail_cnt_d;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: one instance with tail bits, one without.
// Inputs change 1 ns after the rising edge and outputs are sampled on the falling edge.
module tb_conv_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       s_valid, s_ready, s_last, m_valid, m_ready, m_last;
    logic [7:0] s_data;
    logic [1:0] m_sym;

    logic       n_s_valid, n_s_ready, n_s_last, n_m_valid, n_m_ready, n_m_last;
    logic [7:0] n_s_data;
    logic [1:0] n_m_sym;

    int checks = 0;
    int fails  = 0;

    // Hand-derived with c0 = u^s1^s0, c1 = u^s0, symbol = {c0,c1}.
    int exp_b0[10]   = '{3, 2, 0, 1, 1, 3, 0, 0, 0, 0};
    int exp_ff00[18] = '{3, 1, 2, 2, 2, 2, 2, 2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0};

    conv_encoder #(.TERMINATE(1'b1)) dut_t (
        .clk_i(clk), .rst_ni(rst_n),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data), .s_last_i(s_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_sym_o(m_sym), .m_last_o(m_last)
    );

    conv_encoder #(.TERMINATE(1'b0)) dut_n (
        .clk_i(clk), .rst_ni(rst_n),
        .s_valid_i(n_s_valid), .s_ready_o(n_s_ready), .s_data_i(n_s_data), .s_last_i(n_s_last),
        .m_valid_o(n_m_valid), .m_ready_i(n_m_ready), .m_sym_o(n_m_sym), .m_last_o(n_m_last)
    );

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
        n_s_valid = 1'b0; n_s_data = 8'h00; n_s_last = 1'b0; n_m_ready = 1'b1;
        #12;
        checks++;
        if ({m_valid, m_sym, m_last, s_ready} !== 5'b0_00_0_1) begin
            fails++;
            $display("FAIL reset_t: got v=%b sym=%b last=%b rdy=%b, want 0 00 0 1", m_valid, m_sym, m_last, s_ready);
        end
        checks++;
        if ({n_m_valid, n_m_sym, n_m_last, n_s_ready} !== 5'b0_00_0_1) begin
            fails++;
            $display("FAIL reset_n: got v=%b sym=%b last=%b rdy=%b, want 0 00 0 1", n_m_valid, n_m_sym, n_m_last, n_s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
    endtask

    task automatic test_single_byte();
        s_valid = 1'b1; s_data = 8'hB0; s_last = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_accept: got rdy=%b v=%b, want rdy=1 v=0", s_ready, m_valid);
        end
        next_cyc();
        s_valid = 1'b0; s_data = 8'h5A; s_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_b0[i][1:0] || m_last !== (i == 9)) begin
                fails++;
                $display("FAIL single_sym[%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=%b",
                         i, m_valid, m_sym, m_last, exp_b0[i], (i == 9));
            end
            next_cyc();
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_sym !== 2'b00) begin
            fails++;
            $display("FAIL single_idle: got v=%b rdy=%b sym=%b, want v=0 rdy=1 sym=00", m_valid, s_ready, m_sym);
        end
        next_cyc();
    endtask

    task automatic test_back_to_back();
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        next_cyc();
        s_data = 8'h00; s_last = 1'b1;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_ff00[i][1:0] || m_last !== (i == 17)) begin
                fails++;
                $display("FAIL b2b_sym[%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=%b",
                         i, m_valid, m_sym, m_last, exp_ff00[i], (i == 17));
            end
            checks++;
            if (s_ready !== (i == 7)) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %b, want %b", i, s_ready, (i == 7));
            end
            next_cyc();
            if (i == 7) begin
                s_valid = 1'b0; s_data = 8'hA5; s_last = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_idle: got v=%b rdy=%b, want v=0 rdy=1", m_valid, s_ready);
        end
        next_cyc();
    endtask

    task automatic test_wait_gap();
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b0; m_ready = 1'b1;
        @(negedge clk);
        next_cyc();
        s_valid = 1'b0; s_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_ff00[i][1:0] || m_last !== 1'b0) begin
                fails++;
                $display("FAIL gap_sym[%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=0",
                         i, m_valid, m_sym, m_last, exp_ff00[i]);
            end
            next_cyc();
        end
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || m_sym !== 2'b00 || m_last !== 1'b0 || s_ready !== 1'b1) begin
                fails++;
                $display("FAIL gap_wait[%0d]: got v=%b sym=%b last=%b rdy=%b, want 0 00 0 1",
                         g, m_valid, m_sym, m_last, s_ready);
            end
            next_cyc();
        end
        s_valid = 1'b1; s_data = 8'h00; s_last = 1'b1;
        @(negedge clk);
        next_cyc();
        s_valid = 1'b0; s_data = 8'hC3; s_last = 1'b0;
        for (int i = 8; i < 18; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_ff00[i][1:0] || m_last !== (i == 17)) begin
                fails++;
                $display("FAIL gap_sym[%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=%b",
                         i, m_valid, m_sym, m_last, exp_ff00[i], (i == 17));
            end
            next_cyc();
        end
    endtask

    task automatic test_stall();
        int k;
        s_valid = 1'b1; s_data = 8'hB0; s_last = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        next_cyc();
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && k < 10; c++) begin
            m_ready = ((c % 4) == 0) || ((c % 4) == 3);
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_b0[k][1:0] || m_last !== (k == 9)) begin
                fails++;
                $display("FAIL stall_sym[c%0d,k%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=%b",
                         c, k, m_valid, m_sym, m_last, exp_b0[k], (k == 9));
            end
            if (m_ready) k++;
            next_cyc();
        end
        m_ready = 1'b1;
        checks++;
        if (k != 10) begin
            fails++;
            $display("FAIL stall_count: got %0d symbols, want 10", k);
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_idle: got v=%b, want 0", m_valid);
        end
        next_cyc();
    endtask

    task automatic test_no_tail();
        for (int f = 0; f < 2; f++) begin
            n_s_valid = 1'b1; n_s_data = 8'hB0; n_s_last = 1'b1; n_m_ready = 1'b1;
            @(negedge clk);
            next_cyc();
            n_s_valid = 1'b0; n_s_data = 8'h00; n_s_last = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                checks++;
                if (n_m_valid !== 1'b1 || n_m_sym !== exp_b0[i][1:0] || n_m_last !== (i == 7)) begin
                    fails++;
                    $display("FAIL notail_sym[f%0d,%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=%b",
                             f, i, n_m_valid, n_m_sym, n_m_last, exp_b0[i], (i == 7));
                end
                next_cyc();
            end
            @(negedge clk);
            checks++;
            if (n_m_valid !== 1'b0 || n_s_ready !== 1'b1) begin
                fails++;
                $display("FAIL notail_idle[%0d]: got v=%b rdy=%b, want v=0 rdy=1", f, n_m_valid, n_s_ready);
            end
            next_cyc();
        end
    endtask

    task automatic test_reset_abort();
        s_valid = 1'b1; s_data = 8'hB0; s_last = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        next_cyc();
        s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b1 || m_sym !== exp_b0[i][1:0] || m_last !== 1'b0) begin
                fails++;
                $display("FAIL abort_sym[%0d]: got v=%b sym=%0d last=%b, want v=1 sym=%0d last=0",
                         i, m_valid, m_sym, m_last, exp_b0[i]);
            end
            if (i < 3) next_cyc();
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({m_valid, m_sym, m_last, s_ready} !== 5'b0_00_0_1) begin
            fails++;
            $display("FAIL abort_async: got v=%b sym=%b last=%b rdy=%b, want 0 00 0 1", m_valid, m_sym, m_last, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        test_single_byte();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_wait_gap();
        test_stall();
        test_no_tail();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
